// File: rtl/vram_write_queue.sv
// Posted-write FIFO between CPU snoop stage and the shared VRAM port.
// Latency: 1 pixClk minimum from request to strobe; strobes only on seq==WR_SLOT or blank.
// Backpressure: none upstream; a push to a full queue with no pop is dropped and overflow sticks.
//
// Ports:
//   pixClk, reset         - pixel clock, synchronous active-high reset
//   seq, blank            - pixel phase and blanking flag (write-slot qualifiers)
//   inWrReq/inAddr/inData - one-cycle write request from the snoop stage
//   vramAddr/vramDataOut  - registered write being issued (held between writes)
//   nvramWE               - active-low strobe, low for one cycle per write
//   full/empty/overflow   - registered status; overflow is sticky until reset
//   level                 - current entry count
//
// Build option: define SEVGA_WRQ_COALESCE_EN to merge a push into the tail-most
// entry when the addresses match (data replaced in place, level unchanged).
module vram_write_queue #(
  parameter int          DEPTH   = 4,
  parameter logic [2:0]  WR_SLOT = 3'd4
) (
  input  logic                       pixClk,
  input  logic                       reset,
  input  logic [2:0]                 seq,
  input  logic                       blank,
  input  logic                       inWrReq,
  input  logic [14:0]                inAddr,
  input  logic [7:0]                 inData,
  output logic [14:0]                vramAddr,
  output logic [7:0]                 vramDataOut,
  output logic                       nvramWE,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int             LW      = $clog2(DEPTH + 1);
  localparam int             PW      = $clog2(DEPTH);
  localparam logic [LW-1:0]  DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0]  ONE_L   = LW'(1);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          nwe_q, nwe_d;
  logic [14:0]   vaddr_q, vaddr_d;
  logic [7:0]    vdata_q, vdata_d;
  logic [14:0]   addr_mem_q [DEPTH];
  logic [14:0]   addr_mem_d [DEPTH];
  logic [7:0]    data_mem_q [DEPTH];
  logic [7:0]    data_mem_d [DEPTH];

  logic pop, coal, push, drop, full_now;

  // Pop decision uses the pre-edge level, so an entry pushed on this edge
  // can never issue before the next one.
  assign pop      = (level_q != '0) && ((seq == WR_SLOT) || blank);
  assign full_now = (level_q == DEPTH_L);

`ifdef SEVGA_WRQ_COALESCE_EN
  logic [PW-1:0] last_idx;
  assign last_idx = tail_q - PW'(1);
  // The tail-most entry is only being popped when it is also the sole entry.
  assign coal = inWrReq && (level_q != '0) && (addr_mem_q[last_idx] == inAddr)
                && !(pop && (level_q == ONE_L));
`else
  assign coal = 1'b0;
`endif

  // A pop on the same edge frees a slot, so a full queue still accepts.
  assign push = inWrReq && !coal && (!full_now || pop);
  assign drop = inWrReq && !coal && full_now && !pop;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;
    nwe_d      = 1'b1;
    vaddr_d    = vaddr_q;
    vdata_d    = vdata_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;

    if (pop) begin
      vaddr_d = addr_mem_q[head_q];
      vdata_d = data_mem_q[head_q];
      nwe_d   = 1'b0;
      head_d  = head_q + PW'(1);
    end

    if (push) begin
      addr_mem_d[tail_q] = inAddr;
      data_mem_d[tail_q] = inData;
      tail_d             = tail_q + PW'(1);
    end

`ifdef SEVGA_WRQ_COALESCE_EN
    if (coal) begin
      data_mem_d[last_idx] = inData;
    end
`endif

    case ({push, pop})
      2'b10:   level_d = level_q + ONE_L;
      2'b01:   level_d = level_q - ONE_L;
      default: level_d = level_q;
    endcase

    full_d  = (level_d == DEPTH_L);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge pixClk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      nwe_q      <= 1'b1;
      vaddr_q    <= '0;
      vdata_q    <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      nwe_q      <= nwe_d;
      vaddr_q    <= vaddr_d;
      vdata_q    <= vdata_d;
    end
  end

  // Entry storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge pixClk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign vramAddr    = vaddr_q;
  assign vramDataOut = vdata_q;
  assign nvramWE     = nwe_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign overflow    = overflow_q;
  assign level       = level_q;

endmodule

// File: tb/tb_vram_write_queue.sv
// Directed bench for vram_write_queue: reset, slot timing, blank burst,
// overflow, full with simultaneous pop, and same-address back-to-back writes.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_vram_write_queue;

  logic        pixClk = 1'b0;
  logic        reset;
  logic [2:0]  seq;
  logic        blank;
  logic        inWrReq;
  logic [14:0] inAddr;
  logic [7:0]  inData;
  logic [14:0] vramAddr;
  logic [7:0]  vramDataOut;
  logic        nvramWE;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  vram_write_queue dut (
    .pixClk      (pixClk),
    .reset       (reset),
    .seq         (seq),
    .blank       (blank),
    .inWrReq     (inWrReq),
    .inAddr      (inAddr),
    .inData      (inData),
    .vramAddr    (vramAddr),
    .vramDataOut (vramDataOut),
    .nvramWE     (nvramWE),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .level       (level)
  );

  always #5 pixClk = ~pixClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge; seq advances like hCount[2:0].
  task automatic tick();
    @(posedge pixClk);
    #1;
    seq = seq + 3'd1;
  endtask

  task automatic push_tick(input logic [14:0] a, input logic [7:0] d);
    inWrReq = 1'b1;
    inAddr  = a;
    inData  = d;
    tick();
    inWrReq = 1'b0;
  endtask

  // Advance until a strobe is seen, at most 16 edges.
  task automatic wait_we(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (nvramWE !== 1'b0 && n < 16);
    chk(tag, nvramWE, 0);
  endtask

  // Run n edges and return how many strobes were observed.
  task automatic count_we(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (nvramWE === 1'b0) cnt++;
    end
  endtask

  initial begin
    int cnt;
    reset   = 1'b1;
    seq     = 3'd0;
    blank   = 1'b0;
    inWrReq = 1'b0;
    inAddr  = '0;
    inData  = '0;

    // ---------------- reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_we",    nvramWE, 1);
    chk("rst_addr",  vramAddr, 0);
    chk("rst_data",  vramDataOut, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_ovf",   overflow, 0);

    // ---------------- active display: push at seq=1, issue at seq=4
    seq = 3'd1;
    push_tick(15'h1234, 8'hA5);           // edge seq=1
    chk("act_level1", level, 1);
    chk("act_we_s1", nvramWE, 1);
    tick();                               // edge seq=2
    chk("act_we_s2", nvramWE, 1);
    tick();                               // edge seq=3
    chk("act_we_s3", nvramWE, 1);
    tick();                               // edge seq=4 -> pop
    chk("act_we_s4", nvramWE, 0);
    chk("act_addr",  vramAddr, 32'h1234);
    chk("act_data",  vramDataOut, 32'hA5);
    chk("act_empty", empty, 1);
    count_we(4, cnt);                     // edges seq=5,6,7,0
    chk("act_no_extra", cnt, 0);
    chk("act_hold_addr", vramAddr, 32'h1234);

    // ---------------- blanking burst: 4 pushes, strobes one edge behind
    blank = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) push_tick(15'h0200 + 15'(i), 8'h30 + 8'(i));
      else       tick();
      if (i == 0) begin
        chk("blk_we_first", nvramWE, 1);
      end else begin
        chk("blk_we",   nvramWE, 0);
        chk("blk_addr", vramAddr, 32'h0200 + i - 1);
        chk("blk_data", vramDataOut, 32'h30 + i - 1);
      end
    end
    tick();
    chk("blk_we_done", nvramWE, 1);
    chk("blk_empty",   empty, 1);

    // ---------------- overflow: 5 pushes at seq 5,6,7,0,1
    blank = 1'b0;
    seq   = 3'd5;
    for (int i = 0; i < 5; i++) begin
      push_tick(15'h0300 + 15'(i), 8'h40 + 8'(i));
      if (i == 3) begin
        chk("ovf_full4",  full, 1);
        chk("ovf_level4", level, 4);
        chk("ovf_clear4", overflow, 0);
      end
    end
    chk("ovf_set",   overflow, 1);
    chk("ovf_full5", full, 1);
    chk("ovf_level5", level, 4);
    for (int i = 0; i < 4; i++) begin
      wait_we("ovf_wait");
      chk("ovf_seq",  seq, 5);            // strobe came from the seq=4 edge
      chk("ovf_addr", vramAddr, 32'h0300 + i);
      chk("ovf_data", vramDataOut, 32'h40 + i);
    end
    count_we(16, cnt);
    chk("ovf_5th_dropped", cnt, 0);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_empty",  empty, 1);

    // ---------------- reset mid-traffic: 3 queued plus one strobe in flight
    seq = 3'd0;
    for (int i = 0; i < 4; i++) push_tick(15'h0400 + 15'(i), 8'h50 + 8'(i));
    tick();                               // edge seq=4 pops first entry
    chk("mid_we",    nvramWE, 0);
    chk("mid_level", level, 3);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("mid_rst_we",    nvramWE, 1);
    chk("mid_rst_addr",  vramAddr, 0);
    chk("mid_rst_data",  vramDataOut, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ovf",   overflow, 0);
    count_we(16, cnt);
    chk("mid_discarded", cnt, 0);

    // ---------------- full with simultaneous pop
    seq = 3'd0;
    for (int i = 0; i < 4; i++) push_tick(15'h0500 + 15'(i), 8'h60 + 8'(i));
    chk("fp_full", full, 1);
    push_tick(15'h0504, 8'h64);           // edge seq=4: pop and push
    chk("fp_level", level, 4);
    chk("fp_full_after", full, 1);
    chk("fp_ovf",  overflow, 0);
    chk("fp_we",   nvramWE, 0);
    chk("fp_addr", vramAddr, 32'h0500);
    for (int i = 1; i < 5; i++) begin
      wait_we("fp_wait");
      chk("fp_drain_addr", vramAddr, 32'h0500 + i);
      chk("fp_drain_data", vramDataOut, 32'h60 + i);
    end
    chk("fp_empty", empty, 1);

    // ---------------- same address twice before the slot
    seq = 3'd0;
    push_tick(15'h0100, 8'h11);
    push_tick(15'h0100, 8'h22);
`ifdef SEVGA_WRQ_COALESCE_EN
    chk("co_level", level, 1);
    wait_we("co_wait");
    chk("co_addr", vramAddr, 32'h0100);
    chk("co_data", vramDataOut, 32'h22);
    count_we(16, cnt);
    chk("co_single", cnt, 0);
`else
    chk("nc_level", level, 2);
    wait_we("nc_wait1");
    chk("nc_addr1", vramAddr, 32'h0100);
    chk("nc_data1", vramDataOut, 32'h11);
    wait_we("nc_wait2");
    chk("nc_addr2", vramAddr, 32'h0100);
    chk("nc_data2", vramDataOut, 32'h22);
`endif
    chk("final_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_write_queue.md
Name: vram_write_queue

Overview:
- Write-posting FIFO between the CPU snoop stage and the shared VRAM port.
- Accepts single-cycle VRAM write requests (15-bit address, 8-bit data) captured from CPU bus snooping.
- Releases writes only in the pixel-sequence slot reserved for writes, or at any time during blanking, so CPU writes never collide with video fetches.
- Output drives the VRAM address/data/WE mux in the top level.

Parameters:
- DEPTH, 4, number of queued write entries; power of two, 2..16.
- WR_SLOT, 3'd4, value of seq in which a write may issue during active display.

Ports:
- pixClk  input  1  25.175MHz pixel clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- seq  input  3  pixel sequence phase (hCount[2:0]).
- blank  input  1  1 = outside SE active window; any cycle is a write slot.
- inWrReq  input  1  one-cycle write request from snoop stage.
- inAddr  input  15  VRAM byte address, sampled when inWrReq=1.
- inData  input  8  VRAM byte data, sampled when inWrReq=1.
- vramAddr  output  15  address of the write being issued.
- vramDataOut  output  8  data of the write being issued.
- nvramWE  output  1  active-low write strobe, one pixClk cycle per write.
- full  output  1  queue holds DEPTH entries.
- empty  output  1  queue holds 0 entries.
- overflow  output  1  sticky; a request was dropped.
- level  output  $clog2(DEPTH+1)  current entry count.

Behaviour:
- Reset (synchronous, reset=1 at edge):
  - nvramWE=1, vramAddr=0, vramDataOut=0.
  - level=0, empty=1, full=0, overflow=0.
  - Pointers cleared; any queued or in-flight write is discarded.
  - reset overrides push and pop in the same cycle.
- Storage: circular buffer of DEPTH {addr, data} entries; head/tail pointers wrap modulo DEPTH.
- Push: at an edge with inWrReq=1, the entry is written at tail and level increments.
  - Earliest issue is the following edge (1 cycle minimum latency from request to pop).
- Pop condition at an edge: level>0 (pre-edge value) and (seq==WR_SLOT or blank=1).
  - Head entry is loaded into vramAddr/vramDataOut, and nvramWE=0 for the following cycle only.
- No pop: nvramWE=1; vramAddr/vramDataOut hold their last values.
- Throughput: one write per 8 cycles during active display; one per cycle during blank.
- Simultaneous push and pop: both occur; level unchanged.
  - When full, the pop frees a slot, so the push is accepted (no overflow).
- Push when full with no pop: request dropped, overflow set to 1; it stays 1 until reset.
- Push when empty with pop condition true: no pop that edge (entry is not visible yet); it issues at the next eligible edge.
- Flags are registered and consistent with level after each edge:
  - full = (level==DEPTH)
  - empty = (level==0)
- Ordering: writes issue strictly in acceptance order.

Optional Feature:
- Macro: SEVGA_WRQ_COALESCE_EN.
- Defined: a push whose inAddr equals the address of the tail-most queued entry replaces that entry's data in place.
  - level unchanged; no overflow even when full.
  - Coalescing applies only if level>0 and that entry is not being popped on the same edge.
  - Otherwise the push is a normal push.
- Undefined: every accepted push creates a new entry; there is no address comparison logic.

Test Plan:
- Reset: hold reset 2 cycles mid-traffic, with 3 entries queued and nvramWE=0 in flight -> next cycle nvramWE=1, vramAddr=0, level=0, empty=1, overflow=0.
- Active display: blank=0, push {0x1234, 0xA5} at seq=1 -> pop at the edge with seq=4; nvramWE=0 for exactly one cycle with vramAddr=0x1234 and vramDataOut=0xA5; no other strobe in that 8-cycle window.
- Blanking burst: blank=1, push 4 writes on consecutive cycles -> 4 consecutive nvramWE=0 cycles; data in order, each strobe one cycle after its push.
- Overflow: blank=0, push 5 distinct writes with no slot reached -> full=1 after the 4th, overflow=1 after the 5th; 5th write never issued; first 4 issue in order at subsequent seq=4 edges.
- Full plus simultaneous pop: level=4, push on an edge where seq==4 -> accepted, level stays 4, overflow stays 0.
- SEVGA_WRQ_COALESCE_EN:
  - Defined: push {0x0100, 0x11} then {0x0100, 0x22} before the slot -> level=1, single write of 0x22.
  - Undefined: same stimulus -> two writes, 0x11 then 0x22.
